alu_unit: RTL

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_seq.sv | 81 ++++++++
 rtl/alu_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// =============================================================================
//  Module   : alu_pkg
//  Brief    : Shared constants for the ALU: default width, op codes and FSM
//             state encoding.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// =============================================================================
//  Module   : alu_mul_seq
//  Brief    : Sequential shift-add multiplier, one partial product per cycle,
//             WIDTH cycles per operation. done flags the final step, during
//             which product already carries the complete 2*WIDTH result.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic                busy_q,   busy_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]  acc_q,    acc_d;
    logic [2*WIDTH-1:0]  mcand_q,  mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [2*WIDTH-1:0]  acc_step;

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (!busy_q) begin
            if (start) begin
                busy_d   = 1'b1;
                cnt_d    = '0;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
            end
        end else begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == LAST);
    assign product = acc_step;

endmodule

`default_nettype wire

// File: rtl/alu_unit.sv
// =============================================================================
//  Module   : alu_unit
//  Brief    : Register-group ALU with IDLE/MUL/DONE control FSM, registered
//             result and C/Z flags. Macro ALU_MUL_EN enables the sequential
//             multiplier for op 111; otherwise op 111 is a pass-through of d.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] result,
    output logic             we_n,
    output logic             busy,
    output logic             done,
    output logic             c_flag,
    output logic             z_flag
);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_flag_q, c_flag_d;
    logic             z_flag_q, z_flag_d;

    logic [WIDTH:0]   alu_sum;
    logic [WIDTH:0]   alu_diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_upd;
    logic             is_mul;
    logic             load_single;

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign is_mul    = (op == OP_MUL);
    assign mul_start = (state_q == ST_IDLE) && start && is_mul;

    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (d),
        .b       (s),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    assign load_single = (state_q == ST_IDLE) && start && !is_mul;

    // Single-cycle datapath; the extra MSB of sum/diff is carry/borrow.
    always_comb begin
        alu_sum  = {1'b0, d} + {1'b0, s};
        alu_diff = {1'b0, d} - {1'b0, s};
        alu_res  = d;
        alu_c    = 1'b0;
        alu_upd  = 1'b1;
        case (op)
            OP_ADD:  begin alu_res = alu_sum[WIDTH-1:0];  alu_c = alu_sum[WIDTH];  end
            OP_SUB:  begin alu_res = alu_diff[WIDTH-1:0]; alu_c = alu_diff[WIDTH]; end
            OP_AND:  alu_res = d & s;
            OP_OR:   alu_res = d | s;
            OP_NOT:  alu_res = ~d;
            OP_SHL:  begin alu_res = d << 1; alu_c = d[WIDTH-1]; end
            OP_SHR:  begin alu_res = d >> 1; alu_c = d[0];       end
            default: alu_upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            c_flag_q <= 1'b0;
            z_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            c_flag_q <= c_flag_d;
            z_flag_q <= z_flag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = is_mul ? ST_MUL : ST_DONE;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                // Falling out of MUL without a done step means the multiplier lost track; recover to IDLE.
                if (mul_done) begin
                    state_d = ST_DONE;
                end else if (!mul_busy) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Result and flags only change on the edge that enters DONE.
    always_comb begin
        result_d = result_q;
        c_flag_d = c_flag_q;
        z_flag_d = z_flag_q;
        if (load_single) begin
            result_d = alu_res;
            if (alu_upd) begin
                c_flag_d = alu_c;
                z_flag_d = (alu_res == '0);
            end
        end
`ifdef ALU_MUL_EN
        if ((state_q == ST_MUL) && mul_done) begin
            result_d = mul_product[WIDTH-1:0];
            c_flag_d = |mul_product[2*WIDTH-1:WIDTH];
            z_flag_d = (mul_product[WIDTH-1:0] == '0);
        end
`endif
    end

    always_comb begin
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE);
        we_n   = (state_q != ST_DONE);
        result = result_q;
        c_flag = c_flag_q;
        z_flag = z_flag_q;
    end

endmodule

`default_nettype wire
